// File: rtl/lsu_pkg.sv
// Shared types, RV32I load/store width codes and lane formatting helpers for the LSU.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Select the addressed byte/half of a read word and extend it to 32 bits.
    function automatic logic [31:0] load_extend(input logic [2:0]  funct3,
                                                input logic [1:0]  lane,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_LB:   res = {{24{b[7]}}, b};
            F3_LBU:  res = {24'd0, b};
            F3_LH:   res = {{16{h[15]}}, h};
            F3_LHU:  res = {16'd0, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Byte enables and lane-replicated write data, packed as {be, wdata}.
    function automatic logic [35:0] store_format(input logic [2:0]  funct3,
                                                 input logic [1:0]  lane,
                                                 input logic [31:0] data);
        logic [3:0]  be;
        logic [31:0] wdata;
        case (funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << lane;
                wdata = {4{data[7:0]}};
            end
            2'b01: begin
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wdata = {2{data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = data;
            end
        endcase
        return {be, wdata};
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational extraction and sign/zero extension of a load result.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] word_i,
    output logic [31:0] data_o
);

    // Pick the lane and extend according to the load width code.
    always_comb begin
        data_o = load_extend(funct3_i, lane_i, word_i);
    end

endmodule

// File: rtl/lsu_data_port.sv
// Memory-stage load/store unit: core request -> req/gnt/rvalid bus, with stall,
// access-error and bus-timeout reporting and a registered extended load result.
module lsu_data_port
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  MemReadM,
    input  logic                  MemWriteM,
    input  logic [2:0]            Funct3M,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    output logic                  StallLSU,
    output logic [DATA_WIDTH-1:0] ReadDataW,
    output logic                  AccessErr,
    output logic                  BusErr,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int               CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  is_load_q;
    logic [2:0]            funct3_q;
    logic [1:0]            lane_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  mem_req_q, mem_we_q;
    logic [DATA_WIDTH-1:0] mem_addr_q, mem_wdata_q;
    logic [3:0]            mem_be_q;
    logic                  acc_err_q, bus_err_q;

    logic                  is_store, new_acc, legal, start, illegal;
    logic                  complete, timeout;
    logic [35:0]           st_fmt;
    logic [DATA_WIDTH-1:0] load_val;

    // A simultaneous read and write is treated as a store.
    assign is_store = MemWriteM;
    assign new_acc  = MemReadM | MemWriteM;
    assign st_fmt   = store_format(Funct3M, ALUResultM[1:0], WriteDataM);

    // Width code and alignment legality of the access presented by the core.
    always_comb begin
        legal = 1'b0;
        case (Funct3M)
            F3_LB:   legal = 1'b1;
            F3_LBU:  legal = !is_store;
            F3_LH:   legal = !ALUResultM[0];
            F3_LHU:  legal = !is_store && !ALUResultM[0];
            F3_LW:   legal = (ALUResultM[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    assign start   = (state_q == IDLE) && new_acc && legal;
    assign illegal = (state_q == IDLE) && new_acc && !legal;

    lsu_load_align u_align (
        .funct3_i (funct3_q),
        .lane_i   (lane_q),
        .word_i   (mem_rdata),
        .data_o   (load_val)
    );

    // State and timeout counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state; completion or timeout always return to IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = (state_q == IDLE) ? '0 : cnt_q + CNT_W'(1);
        case (state_q)
            IDLE:    if (start) state_d = REQ;
            REQ: begin
                if (complete || timeout) state_d = IDLE;
                else if (mem_gnt)        state_d = WAIT;
            end
            WAIT:    if (complete || timeout) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Completion, timeout abort and pipeline stall; completion beats timeout.
    always_comb begin
        complete = 1'b0;
        case (state_q)
            REQ:     complete = mem_gnt && (!is_load_q || mem_rvalid);
            WAIT:    complete = mem_rvalid;
            default: complete = 1'b0;
        endcase
        timeout  = (state_q != IDLE) && !complete && (cnt_q == CNT_LAST);
        StallLSU = (state_q == IDLE) ? start : !(complete || timeout);
    end

    // Bus request registers, error pulses and the load result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            is_load_q   <= 1'b0;
            funct3_q    <= '0;
            lane_q      <= '0;
            acc_err_q   <= 1'b0;
            bus_err_q   <= 1'b0;
            rdata_q     <= '0;
        end else begin
            acc_err_q <= illegal;
            bus_err_q <= timeout;
            if (start) begin
                mem_req_q   <= 1'b1;
                mem_we_q    <= is_store;
                mem_addr_q  <= {ALUResultM[DATA_WIDTH-1:2], 2'b00};
                mem_be_q    <= st_fmt[35:32];
                mem_wdata_q <= is_store ? st_fmt[31:0] : '0;
                is_load_q   <= !is_store;
                funct3_q    <= Funct3M;
                lane_q      <= ALUResultM[1:0];
            end else if ((state_q == REQ) && (mem_gnt || timeout)) begin
                mem_req_q <= 1'b0;
            end
            if (complete && is_load_q) begin
                rdata_q <= load_val;
            end else if (timeout && is_load_q) begin
                rdata_q <= '0;
            end
        end
    end

    assign ReadDataW = rdata_q;
    assign AccessErr = acc_err_q;
    assign BusErr    = bus_err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_data_port.sv
// Self-checking bench for lsu_data_port: directed table, hand sequences, random accesses.
module tb_lsu_data_port;

    localparam int TO = 16;

    logic        clk;
    logic        rst_n;
    logic        MemReadM, MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM, WriteDataM;
    logic        StallLSU;
    logic [31:0] ReadDataW;
    logic        AccessErr, BusErr;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        int          g;      // REQ cycles before gnt (0 = first REQ cycle)
        int          r;      // cycles from gnt to rvalid (0 = same cycle)
        logic [31:0] rdata;
        int          stall;  // expected number of StallLSU=1 cycles
        logic [3:0]  be;
        logic [31:0] wdat;
        logic [31:0] rdw;
        bit          aerr;
        bit          berr;
    } vec_t;

    lsu_data_port #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .Funct3M    (Funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .StallLSU   (StallLSU),
        .ReadDataW  (ReadDataW),
        .AccessErr  (AccessErr),
        .BusErr     (BusErr),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // Reference load result: shift the word down to the lane, mask to the size, extend.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input int lane,
                                             input int size, input logic [31:0] word);
        logic [63:0] mask, val;
        mask = (64'd1 << (8 * size)) - 64'd1;
        val  = ({32'd0, word} >> (8 * lane)) & mask;
        if (f3[2] == 1'b0 && size < 4 && val[8*size-1]) val = val - (mask + 64'd1);
        return val[31:0];
    endfunction

    // Transaction-level expectation for one access given the previous ReadDataW.
    function automatic vec_t model(input vec_t v, input logic [31:0] prev);
        vec_t e;
        int   size, lane, ends;
        bit   legal;
        e      = v;
        size   = 1 << v.f3[1:0];
        lane   = int'(v.addr[1:0]);
        legal  = v.wr ? (v.f3 <= 3'd2) : (v.f3 <= 3'd5 && v.f3 != 3'd3);
        legal  = legal && ((lane % size) == 0);
        e.aerr = !legal;
        e.berr = 1'b0;
        e.rdw  = prev;
        e.stall = 0;
        e.be   = 4'd0;
        e.wdat = 32'd0;
        if (legal) begin
            e.be = 4'(((1 << size) - 1) << lane);
            case (size)
                1:       e.wdat = v.wd[7:0] * 32'h01010101;
                2:       e.wdat = v.wd[15:0] * 32'h00010001;
                default: e.wdat = v.wd;
            endcase
            ends = v.wr ? v.g : v.g + v.r;
            if (ends <= TO - 1) begin
                e.stall = 1 + ends;
                if (!v.wr) e.rdw = ref_load(v.f3, lane, size, v.rdata);
            end else begin
                e.stall = TO;
                e.berr  = 1'b1;
                if (!v.wr) e.rdw = 32'd0;
            end
        end
        return e;
    endfunction

    // Present one access, play the memory side, and compare against v's expectations.
    task automatic run_vec(input vec_t v, input string tag);
        int c;
        int hold_bad;
        bit done;
        bit ld;
        ld = !v.wr;
        MemReadM   = v.rd;
        MemWriteM  = v.wr;
        Funct3M    = v.f3;
        ALUResultM = v.addr;
        WriteDataM = v.wd;
        mem_rdata  = v.rdata;
        hold_bad   = 0;
        done       = 1'b0;
        c          = 0;
        while (!done && c < 40) begin
            mem_gnt    = (c >= 1) && (c - 1 == v.g);
            mem_rvalid = ld && (c >= 1) && (c - 1 == v.g + v.r);
            @(negedge clk);
            if (c >= 1) begin
                if (c - 1 <= v.g) begin
                    if (mem_req !== 1'b1 || mem_addr !== {v.addr[31:2], 2'b00} ||
                        mem_be !== v.be || mem_we !== v.wr ||
                        (v.wr && mem_wdata !== v.wdat)) hold_bad++;
                end else if (mem_req !== 1'b0) begin
                    hold_bad++;
                end
            end
            if (StallLSU !== 1'b1) done = 1'b1;
            else c++;
            @(posedge clk); #1;
        end
        MemReadM   = 1'b0;
        MemWriteM  = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        if (done) check({tag, " stall_cycles"}, 32'(c), 32'(v.stall));
        else      check({tag, " stall_budget"}, 32'd1, 32'd0);
        check({tag, " req_hold"}, 32'(hold_bad), 32'd0);
        @(negedge clk);
        check({tag, " AccessErr"}, {31'd0, AccessErr}, {31'd0, v.aerr});
        check({tag, " BusErr"}, {31'd0, BusErr}, {31'd0, v.berr});
        check({tag, " ReadDataW"}, ReadDataW, v.rdw);
        check({tag, " req_idle"}, {31'd0, mem_req}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, " err_pulse_clear"}, {30'd0, AccessErr, BusErr}, 32'd0);
        @(posedge clk); #1;
    endtask

    vec_t        tbl [18];
    vec_t        v, e;
    logic [31:0] prev;
    int          sel;

    initial begin
        tbl[0]  = '{1, 0, 3'b010, 32'h100, 32'h0,        0, 0 + 1, 32'hDEADBEEF, 2,  4'hF, 32'h0,        32'hDEADBEEF, 0, 0};
        tbl[1]  = '{1, 0, 3'b000, 32'h103, 32'h0,        0, 1,     32'h80AABBCC, 2,  4'h8, 32'h0,        32'hFFFFFF80, 0, 0};
        tbl[2]  = '{1, 0, 3'b100, 32'h103, 32'h0,        0, 1,     32'h80AABBCC, 2,  4'h8, 32'h0,        32'h00000080, 0, 0};
        tbl[3]  = '{1, 0, 3'b101, 32'h102, 32'h0,        0, 1,     32'h80AABBCC, 2,  4'hC, 32'h0,        32'h000080AA, 0, 0};
        tbl[4]  = '{0, 1, 3'b000, 32'h201, 32'h12345678, 3, 0,     32'h0,        4,  4'h2, 32'h78787878, 32'h000080AA, 0, 0};
        tbl[5]  = '{1, 0, 3'b001, 32'h101, 32'h0,        0, 1,     32'hFFFFFFFF, 0,  4'h0, 32'h0,        32'h000080AA, 1, 0};
        tbl[6]  = '{0, 1, 3'b010, 32'h102, 32'hCAFE0000, 0, 0,     32'h0,        0,  4'h0, 32'h0,        32'h000080AA, 1, 0};
        tbl[7]  = '{1, 0, 3'b010, 32'h010, 32'h0,        2, 0,     32'h11223344, 3,  4'hF, 32'h0,        32'h11223344, 0, 0};
        tbl[8]  = '{1, 0, 3'b010, 32'h030, 32'h0,        0, 999,   32'h99999999, 16, 4'hF, 32'h0,        32'h00000000, 0, 1};
        tbl[9]  = '{1, 0, 3'b010, 32'h020, 32'h0,        0, 1,     32'hCAFEF00D, 2,  4'hF, 32'h0,        32'hCAFEF00D, 0, 0};
        tbl[10] = '{0, 1, 3'b001, 32'h002, 32'hAAAA5555, 0, 0,     32'h0,        1,  4'hC, 32'h55555555, 32'hCAFEF00D, 0, 0};
        tbl[11] = '{1, 0, 3'b001, 32'h006, 32'h0,        1, 2,     32'h80017FFF, 4,  4'hC, 32'h0,        32'hFFFF8001, 0, 0};
        tbl[12] = '{1, 1, 3'b010, 32'h040, 32'h0BADF00D, 0, 0,     32'h12345678, 1,  4'hF, 32'h0BADF00D, 32'hFFFF8001, 0, 0};
        tbl[13] = '{1, 0, 3'b010, 32'h050, 32'h0,        5, 10,    32'h5A5A5A5A, 16, 4'hF, 32'h0,        32'h5A5A5A5A, 0, 0};
        tbl[14] = '{0, 1, 3'b010, 32'h060, 32'h01020304, 20, 0,    32'h0,        16, 4'hF, 32'h01020304, 32'h5A5A5A5A, 0, 1};
        tbl[15] = '{1, 0, 3'b011, 32'h000, 32'h0,        0, 1,     32'h0,        0,  4'h0, 32'h0,        32'h5A5A5A5A, 1, 0};
        tbl[16] = '{0, 1, 3'b100, 32'h000, 32'h0,        0, 0,     32'h0,        0,  4'h0, 32'h0,        32'h5A5A5A5A, 1, 0};
        tbl[17] = '{1, 0, 3'b000, 32'h007, 32'h0,        0, 1,     32'h7F000000, 2,  4'h8, 32'h0,        32'h0000007F, 0, 0};

        rst_n      = 1'b0;
        MemReadM   = 1'b0;
        MemWriteM  = 1'b0;
        Funct3M    = 3'd0;
        ALUResultM = 32'd0;
        WriteDataM = 32'd0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset ReadDataW", ReadDataW, 32'd0);
        check("reset mem_req", {31'd0, mem_req}, 32'd0);
        check("reset mem_we", {31'd0, mem_we}, 32'd0);
        check("reset mem_addr", mem_addr, 32'd0);
        check("reset mem_be", {28'd0, mem_be}, 32'd0);
        check("reset mem_wdata", mem_wdata, 32'd0);
        check("reset errs", {30'd0, AccessErr, BusErr}, 32'd0);
        check("reset StallLSU", {31'd0, StallLSU}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 18; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

        // Back-to-back: a store accepted in the IDLE cycle right after a load completes.
        MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h80; mem_rdata = 32'h01020304;
        @(negedge clk);
        check("b2b load_accept_stall", {31'd0, StallLSU}, 32'd1);
        @(posedge clk); #1 mem_gnt = 1'b1;
        @(negedge clk);
        @(posedge clk); #1 mem_gnt = 1'b0; mem_rvalid = 1'b1;
        @(negedge clk);
        check("b2b load_done_stall", {31'd0, StallLSU}, 32'd0);
        @(posedge clk); #1;
        mem_rvalid = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b1; Funct3M = 3'b010;
        ALUResultM = 32'h84; WriteDataM = 32'hA5A5A5A5;
        @(negedge clk);
        check("b2b ReadDataW", ReadDataW, 32'h01020304);
        check("b2b store_accept_stall", {31'd0, StallLSU}, 32'd1);
        @(posedge clk); #1 mem_gnt = 1'b1;
        @(negedge clk);
        check("b2b store_req", {31'd0, mem_req}, 32'd1);
        check("b2b store_addr", mem_addr, 32'h84);
        check("b2b store_we", {31'd0, mem_we}, 32'd1);
        check("b2b store_wdata", mem_wdata, 32'hA5A5A5A5);
        check("b2b store_stall", {31'd0, StallLSU}, 32'd0);
        @(posedge clk); #1 mem_gnt = 1'b0; MemWriteM = 1'b0;
        @(negedge clk);
        check("b2b req_dropped", {31'd0, mem_req}, 32'd0);
        @(posedge clk); #1;

        // Asynchronous reset while a load sits in WAIT, then a stale rvalid after release.
        MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h90; mem_rdata = 32'h0;
        @(negedge clk);
        @(posedge clk); #1 mem_gnt = 1'b1;
        @(negedge clk);
        @(posedge clk); #1 mem_gnt = 1'b0;
        @(negedge clk);
        check("rst wait_stall", {31'd0, StallLSU}, 32'd1);
        check("rst rdw_before", ReadDataW, 32'h01020304);
        #2 rst_n = 1'b0; MemReadM = 1'b0;
        #1;
        check("rst async ReadDataW", ReadDataW, 32'd0);
        check("rst async bus", {mem_req, mem_we, mem_be, 26'd0}, 32'd0);
        check("rst async addr_wdata", mem_addr | mem_wdata, 32'd0);
        check("rst async stall_errs", {29'd0, StallLSU, AccessErr, BusErr}, 32'd0);
        @(posedge clk); #1 mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst stale_rvalid ReadDataW", ReadDataW, 32'd0);
        check("rst stale_rvalid idle", {29'd0, StallLSU, mem_req, BusErr}, 32'd0);
        @(posedge clk); #1 mem_rvalid = 1'b0;

        // Randomized accesses against the transaction-level model.
        prev = 32'd0;
        for (int i = 0; i < 150; i++) begin
            sel     = $urandom_range(1, 3);
            v.rd    = sel[0];
            v.wr    = sel[1];
            v.f3    = 3'($urandom_range(0, 7));
            v.addr  = $urandom;
            if ($urandom_range(0, 3) != 0) v.addr = v.addr & ~((32'd1 << v.f3[1:0]) - 32'd1);
            v.wd    = $urandom;
            v.rdata = $urandom;
            v.g     = ($urandom_range(0, 4) != 0) ? $urandom_range(0, 3) : $urandom_range(10, 20);
            v.r     = ($urandom_range(0, 4) != 0) ? $urandom_range(0, 3) : $urandom_range(5, 20);
            e = model(v, prev);
            run_vec(e, $sformatf("rnd%0d", i));
            prev = e.rdw;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
